// File: rtl/sram_controller.sv
// sram_controller: sequences 32-bit MEM-stage loads and stores onto a 16-bit
// external SRAM as two halfword phases (low half, then high half), holding
// each phase on the pins for ACCESS_CYCLES cycles. While an access is in
// flight, ready=0 freezes the pipeline so the request stays stable.
//
// Optional feature: define SRAM_POSTED_WRITE_EN to turn stores into posted
// writes. The address and data go into a one-entry buffer, so the store does
// not freeze the pipeline while the buffer drains to the SRAM.
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          op_write;     // kind of the access in flight, taken in IDLE
    logic          req;
    logic          phase_last;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [16:0]   word;

    assign req        = rd_en | wr_en;
    assign phase_last = (cnt == CNT_LAST);

`ifdef SRAM_POSTED_WRITE_EN
    logic [31:0] buf_addr;
    logic [31:0] buf_wdata;

    // Capture a store into the posted-write buffer when it is accepted in IDLE.
    // NOTE: the buffer has no reset; it is only read during a write phase,
    // which can only start after it has been loaded.
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en) begin
            buf_addr  <= address;
            buf_wdata <= write_data;
        end
    end

    // A posted write drives the SRAM from the buffer; reads use the live request.
    assign acc_addr  = op_write ? buf_addr  : address;
    assign acc_wdata = op_write ? buf_wdata : write_data;
`else
    // The pipeline is frozen for the whole access, so the live request is stable.
    assign acc_addr  = address;
    assign acc_wdata = write_data;
`endif

    // Word index wraps modulo 2^17; there is no range check.
    assign word = 17'((acc_addr - BASE_ADDR) >> 2);

    // State, phase counter and access kind; reset wins over every transition.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req) begin
                op_write <= wr_en;  // both enables set is treated as a write
            end
        end
    end

    // Load capture: low half on the last LO cycle, high half on the last HI cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (!op_write && phase_last) begin
            if (state == LO) begin
                read_data[15:0] <= sram_dq_in;
            end else if (state == HI) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

    // Next-state and phase-counter logic.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nx = LO;
                    cnt_nx   = '0;
                end
            end
            LO: begin
                if (phase_last) begin
                    state_nx = HI;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HI: begin
                if (phase_last) begin
`ifdef SRAM_POSTED_WRITE_EN
                    state_nx = op_write ? IDLE : DONE;
`else
                    state_nx = DONE;
`endif
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // SRAM pin drive and pipeline freeze, decoded from the current state.
    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        unique case (state)
            IDLE: begin
`ifdef SRAM_POSTED_WRITE_EN
                ready = !req || wr_en;  // an accepted store does not freeze
`else
                ready = !req;
`endif
            end
            LO: begin
                sram_addr = {word, 1'b0};
                if (op_write) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = acc_wdata[15:0];
                end
`ifdef SRAM_POSTED_WRITE_EN
                ready = op_write && !req;  // new requests wait for the drain
`endif
            end
            HI: begin
                sram_addr = {word, 1'b1};
                if (op_write) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = acc_wdata[31:16];
                end
`ifdef SRAM_POSTED_WRITE_EN
                ready = op_write && !req;
`endif
            end
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed vectors for sram_controller against a
// behavioural 16-bit SRAM model. The stimulus pushes the expected completion
// (freeze length, load data) into a queue; a monitor pops it whenever the DUT
// raises ready on an active request.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

`ifdef SRAM_POSTED_WRITE_EN
    localparam int FZ_W  = 0;  // posted store never freezes
    localparam int FZ_RB = 9;  // read behind a draining store: 4 drain + 5 read
`else
    localparam int FZ_W  = 5;
    localparam int FZ_RB = 5;
`endif

    // SRAM model: asynchronous read, write on the rising edge while strobed.
    logic [15:0] mem [0:262143];
    assign sram_dq_in = mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    end

    int we_low_cnt = 0;
    always @(negedge clk) begin
        if (!sram_we_n) we_low_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          freeze;
    } exp_t;
    exp_t sb_q[$];

    // Monitor: count frozen cycles of the current request, compare on completion.
    int freeze = 0;
    always @(negedge clk) begin
        if (rst) begin
            freeze = 0;
        end else if (rd_en || wr_en) begin
            if (!ready) begin
                freeze++;
            end else begin
                if (sb_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("freeze_cycles", freeze, e.freeze);
                    if (e.is_read) check("read_data", read_data, e.data);
                end
                freeze = 0;
            end
        end
    end

    logic [17:0] trace_addr [64];
    bit          trace_ready[64];

    // Issue one request, hold it until ready, then release after the completing edge.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input bit exp_read,
                             input logic [31:0] exp_data, input int exp_freeze,
                             output int lat);
        bit done = 1'b0;
        int cyc  = 0;
        exp_t e;
        e.is_read = exp_read;
        e.data    = exp_data;
        e.freeze  = exp_freeze;
        sb_q.push_back(e);
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        while (!done && cyc < 64) begin
            @(negedge clk);
            trace_addr[cyc]  = sram_addr;
            trace_ready[cyc] = ready;
            if (ready) done = 1'b1;
            cyc++;
        end
        check("access_timeout", {31'd0, done}, 32'd1);
        lat = cyc - 1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat1, lat2, w0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[4] = 16'hBEEF;
        mem[5] = 16'hDEAD;
        mem[7] = 16'h7777;

        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values with no request present.
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_addr", {14'd0, sram_addr}, 32'd0);
        check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        @(posedge clk);
        #1;

        // Load of 1032: halfwords 4 then 5, five frozen cycles.
        do_access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b1, 32'hDEADBEEF, 5, lat1);
        check("rd_ready_c0", {31'd0, trace_ready[0]}, 32'd0);
        check("rd_addr_c1", {14'd0, trace_addr[1]}, 32'd4);
        check("rd_addr_c2", {14'd0, trace_addr[2]}, 32'd4);
        check("rd_addr_c3", {14'd0, trace_addr[3]}, 32'd5);
        check("rd_addr_c4", {14'd0, trace_addr[4]}, 32'd5);
        check("rd_ready_c5", {31'd0, trace_ready[5]}, 32'd1);
        idle(3);

        // Both enables set: a write happens and the load result is untouched.
        w0 = we_low_cnt;
        do_access(1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5, 1'b0, 32'd0, FZ_W, lat1);
        idle(6);
        check("both_read_data", read_data, 32'hDEADBEEF);
        check("both_mem8", {16'd0, mem[8]}, 32'h0000A5A5);
        check("both_mem9", {16'd0, mem[9]}, 32'h0000A5A5);
        check("both_we_cycles", we_low_cnt - w0, 32'd4);

        // Store of 0x12345678 to 1024: halfwords 0 and 1, strobe low four cycles.
        w0 = we_low_cnt;
        do_access(1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0, 32'd0, FZ_W, lat1);
`ifndef SRAM_POSTED_WRITE_EN
        check("wr_ready_c4", {31'd0, trace_ready[4]}, 32'd0);
        check("wr_ready_c5", {31'd0, trace_ready[5]}, 32'd1);
`else
        check("wr_ready_c0", {31'd0, trace_ready[0]}, 32'd1);
`endif
        idle(6);
        check("wr_mem0", {16'd0, mem[0]}, 32'h00005678);
        check("wr_mem1", {16'd0, mem[1]}, 32'h00001234);
        check("wr_we_cycles", we_low_cnt - w0, 32'd4);

        // Back-to-back store then load of 1028; the load returns the stored word.
        do_access(1'b0, 1'b1, 32'd1028, 32'h0BADF00D, 1'b0, 32'd0, FZ_W, lat1);
        do_access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 32'h0BADF00D, FZ_RB, lat2);
        check("b2b_total_freeze", lat1 + lat2, FZ_W + FZ_RB);
        idle(3);

        // Reset during the second cycle of a store to 1036 (halfwords 6, 7).
`ifdef SRAM_POSTED_WRITE_EN
        begin
            exp_t e;
            e.is_read = 1'b0;
            e.data    = '0;
            e.freeze  = 0;
            sb_q.push_back(e);
        end
`endif
        wr_en      = 1'b1;
        address    = 32'd1036;
        write_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_mid_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_mid_read_data", read_data, 32'd0);
        check("rst_mid_ready", {31'd0, ready}, 32'd1);
        idle(6);
        check("rst_mid_mem7", {16'd0, mem[7]}, 32'h00007777);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller sequencing 32-bit word loads and stores from the MEM stage onto a 16-bit external SRAM. Each word becomes two halfword phases: low half first, then high half. `ready` low freezes the whole pipeline, so the MEM-stage request stays stable until the access completes. The hazard/forwarding logic is unchanged; the freeze gates every pipeline register enable.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address mapped to SRAM halfword 0.
- `ACCESS_CYCLES`, default 2: cycles each halfword phase is held on the pins; legal range ≥1.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rd_en` input 1: load request from MEM stage.
- `wr_en` input 1: store request from MEM stage.
- `address` input 32: byte address from ALU result.
- `write_data` input 32: store data.
- `read_data` output 32: load result; valid while `ready`=1 in DONE.
- `ready` output 1: 0 freezes the pipeline.
- `sram_addr` output 18: halfword address.
- `sram_dq_out` output 16: write data to SRAM.
- `sram_dq_oe` output 1: drive enable for `sram_dq_out`.
- `sram_dq_in` input 16: read data from SRAM.
- `sram_we_n` output 1: active-low write strobe.

## Operation
- Word index is `(address - BASE_ADDR) >> 2`, truncated to 17 bits, so it wraps modulo 2^17 with no range check.
- Low phase uses `sram_addr = {word,1'b0}`; high phase uses `{word,1'b1}`.
- FSM states: IDLE, LO, HI, DONE. A per-phase counter counts 0..ACCESS_CYCLES-1.
- IDLE: if `wr_en` or `rd_en` is set, go to LO and clear the counter; otherwise stay in IDLE.
- LO: when the counter reaches ACCESS_CYCLES-1, go to HI and clear the counter.
- HI: when the counter reaches ACCESS_CYCLES-1, go to DONE.
- DONE: go to IDLE unconditionally.
- `ready` is combinational:
  - 1 in IDLE with no request.
  - 1 in DONE.
  - 0 otherwise.
- Read:
  - `sram_we_n`=1 and `sram_dq_oe`=0.
  - `read_data[15:0]` captures `sram_dq_in` on the last LO cycle.
  - `read_data[31:16]` captures it on the last HI cycle.
  - `read_data` holds its value until the next read capture.
- Write:
  - During LO and HI, `sram_we_n`=0 and `sram_dq_oe`=1.
  - `sram_dq_out` is `write_data[15:0]` in LO and `write_data[31:16]` in HI.
  - Outside LO and HI, `sram_we_n`=1 and `sram_dq_oe`=0.
- `rd_en` and `wr_en` both set is illegal; the block treats it as a write.
- Request inputs are sampled only in IDLE; changes during LO, HI or DONE are ignored.
- Reset values: state IDLE, counter 0, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1.
- `ready` is 1 after reset when no request is present.

## Timing
- With N=ACCESS_CYCLES and a request present in IDLE at cycle 0:
  - LO covers cycles 1..N.
  - HI covers cycles N+1..2N.
  - DONE is cycle 2N+1.
  - `ready`=0 for cycles 0..2N and `ready`=1 on cycle 2N+1.
  - The total freeze is 2N+1 cycles.
- Back-to-back accesses: the next instruction's request is seen in IDLE on cycle 2N+2. There is no dead cycle beyond the IDLE evaluation.
- `rst` mid-access returns to IDLE on the next edge. An in-flight write may leave only the low half written; this is accepted. Read capture is abandoned.
- `rst` has priority over every transition.

## Configuration
- `SRAM_POSTED_WRITE_EN` defined:
  - A write seen in IDLE latches `address` and `write_data` into a one-entry buffer.
  - `ready`=1 in that same cycle, so there is no freeze.
  - The block runs LO then HI from the buffer and returns to IDLE, skipping DONE.
  - Any request seen while the buffer drains (LO/HI) gets `ready`=0 until IDLE, then proceeds normally.
  - Cycles with no request during the drain keep `ready`=1.
  - Reads are unchanged.
- `SRAM_POSTED_WRITE_EN` undefined: writes follow the blocking sequence in Operation.

## Test plan
- Read, N=2, `address`=1032, SRAM model holds halfword 4=0xBEEF and halfword 5=0xDEAD → `sram_addr` is 4 then 5, `ready` low for 5 cycles, `read_data`=0xDEADBEEF on cycle 5.
- Write, `address`=1024, `write_data`=0x12345678 → halfword 0=0x5678, halfword 1=0x1234, `sram_we_n` low exactly 4 cycles, `ready` high on cycle 5.
- Back-to-back write to 1028 then read of 1028 → read returns the written word; total freeze is 10 cycles.
- `rst` asserted on cycle 2 of a write → on the next cycle state is IDLE, `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0; halfword 1 is unchanged.
- Both enables set with `write_data`=0xA5A5A5A5 → a write occurs and `read_data` is unchanged.
- `SRAM_POSTED_WRITE_EN` defined: write then a read on the next cycle → write cycle `ready`=1; read sees `ready`=0 until the drain finishes, then a full 5-cycle read returns the posted data.
